// File: rtl/regfile_mp_if.sv
// Bus bundle for regfile_mp: read, write, flags, reserve and scoreboard signals.
// The master side drives selects and strobes; the slave side is the register file.
interface regfile_mp_if #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 15,
    parameter int RD_PORTS = 2,
    parameter int FLAG_W   = 4
);
    localparam int ADDR_W = $clog2(NUM_REGS);

    logic                       not_enable;
    logic [RD_PORTS*ADDR_W-1:0] rd_sel;
    logic [RD_PORTS*DATA_W-1:0] rd_data;
    logic [RD_PORTS-1:0]        rd_busy;
    logic                       wr_en;
    logic [ADDR_W-1:0]          wr_sel;
    logic [DATA_W-1:0]          wr_data;
    logic                       flags_wr_en;
    logic [FLAG_W-1:0]          in_flags;
    logic [FLAG_W-1:0]          out_flags;
    logic                       rsv_en;
    logic [ADDR_W-1:0]          rsv_sel;
    logic [NUM_REGS-1:0]        busy_mask;
    logic                       err_addr;

    modport master (
        output not_enable, rd_sel, wr_en, wr_sel, wr_data, flags_wr_en, in_flags, rsv_en, rsv_sel,
        input  rd_data, rd_busy, out_flags, busy_mask, err_addr
    );

    modport slave (
        input  not_enable, rd_sel, wr_en, wr_sel, wr_data, flags_wr_en, in_flags, rsv_en, rsv_sel,
        output rd_data, rd_busy, out_flags, busy_mask, err_addr
    );
endinterface

// File: rtl/regfile_mp.sv
// Multi-port register file with flags register and per-register busy scoreboard.
// Define REGFILE_BYPASS_EN to forward same-cycle writes/flags onto the read outputs.
module regfile_mp #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 15,
    parameter int RD_PORTS = 2,
    parameter int FLAG_W   = 4
) (
    input logic         clock,
    input logic         reset,
    regfile_mp_if.slave bus
);
    localparam int ADDR_W = $clog2(NUM_REGS);

    logic [DATA_W-1:0]          regs_q [NUM_REGS];
    logic [NUM_REGS-1:0]        busy_q, busy_d;
    logic [FLAG_W-1:0]          flags_q, flags_d;
    logic [FLAG_W-1:0]          out_flags_q, out_flags_d;
    logic [RD_PORTS*DATA_W-1:0] rd_data_q, rd_data_d;
    logic [RD_PORTS-1:0]        rd_busy_q, rd_busy_d;
    logic                       err_q, err_d;
    logic                       en, wr_ok, rsv_ok;
    logic [ADDR_W-1:0]          rsel;

    function automatic logic in_range(input logic [ADDR_W-1:0] sel);
        return 32'(sel) < 32'(NUM_REGS);
    endfunction

    always_comb begin
        en     = !bus.not_enable;
        wr_ok  = en && bus.wr_en && in_range(bus.wr_sel);
        rsv_ok = en && bus.rsv_en && in_range(bus.rsv_sel);
        err_d  = en && ((bus.wr_en && !in_range(bus.wr_sel)) ||
                        (bus.rsv_en && !in_range(bus.rsv_sel)));

        // Reserve is applied after the write so a new producer supersedes the completing one.
        busy_d = busy_q;
        if (wr_ok)  busy_d[bus.wr_sel]  = 1'b0;
        if (rsv_ok) busy_d[bus.rsv_sel] = 1'b1;

        flags_d = (en && bus.flags_wr_en) ? bus.in_flags : flags_q;
`ifdef REGFILE_BYPASS_EN
        out_flags_d = en ? flags_d : out_flags_q;
`else
        out_flags_d = en ? flags_q : out_flags_q;
`endif

        rd_data_d = rd_data_q;
        rd_busy_d = rd_busy_q;
        rsel      = '0;
        for (int unsigned k = 0; k < RD_PORTS; k++) begin
            if (en) begin
                rsel = bus.rd_sel[k*ADDR_W +: ADDR_W];
                if (!in_range(rsel)) begin
                    err_d                         = 1'b1;
                    rd_data_d[k*DATA_W +: DATA_W] = '0;
                    rd_busy_d[k]                  = 1'b0;
`ifdef REGFILE_BYPASS_EN
                end else if (wr_ok && (rsel == bus.wr_sel)) begin
                    rd_data_d[k*DATA_W +: DATA_W] = bus.wr_data;
                    rd_busy_d[k]                  = rsv_ok && (bus.rsv_sel == rsel);
`endif
                end else begin
                    rd_data_d[k*DATA_W +: DATA_W] = regs_q[rsel];
                    rd_busy_d[k]                  = busy_q[rsel];
                end
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
            busy_q      <= '0;
            flags_q     <= '0;
            out_flags_q <= '0;
            rd_data_q   <= '0;
            rd_busy_q   <= '0;
            err_q       <= 1'b0;
        end else begin
            if (wr_ok) regs_q[bus.wr_sel] <= bus.wr_data;
            busy_q      <= busy_d;
            flags_q     <= flags_d;
            out_flags_q <= out_flags_d;
            rd_data_q   <= rd_data_d;
            rd_busy_q   <= rd_busy_d;
            err_q       <= err_d;
        end
    end

    assign bus.rd_data   = rd_data_q;
    assign bus.rd_busy   = rd_busy_q;
    assign bus.out_flags = out_flags_q;
    assign bus.busy_mask = busy_q;
    assign bus.err_addr  = err_q;
endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: directed vector table, async reset, randomized
// traffic against a behavioural model, and a 16-bit/8-reg/4-port instance.
module tb_regfile_mp;
    localparam int DW = 32, NR = 15, RP = 2, FW = 4, AW = 4;
`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    regfile_mp_if #(.DATA_W(DW), .NUM_REGS(NR), .RD_PORTS(RP), .FLAG_W(FW)) bus ();
    regfile_mp #(.DATA_W(DW), .NUM_REGS(NR), .RD_PORTS(RP), .FLAG_W(FW))
        dut (.clock(clk), .reset(rst), .bus(bus));

    regfile_mp_if #(.DATA_W(16), .NUM_REGS(8), .RD_PORTS(4), .FLAG_W(4)) pbus ();
    regfile_mp #(.DATA_W(16), .NUM_REGS(8), .RD_PORTS(4), .FLAG_W(4))
        dutp (.clock(clk), .reset(rst), .bus(pbus));

    int unsigned n_vec = 0, n_bad = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic        ne, we;
        logic [3:0]  ws;
        logic [31:0] wd;
        logic        fwe;
        logic [3:0]  fl;
        logic        re;
        logic [3:0]  rs, r0, r1;
        logic [31:0] d0, d1;
        logic        b0, b1;
        logic [3:0]  of;
        logic [14:0] mask;
        logic        err;
    } vec_t;

    function automatic vec_t mk(input int ne, we, ws, input logic [31:0] wd, input int fwe, fl,
                                re, rs, r0, r1, input logic [31:0] d0, d1,
                                input int b0, b1, of, mask, err);
        vec_t v;
        v.ne = 1'(ne); v.we = 1'(we); v.ws = 4'(ws); v.wd = wd;
        v.fwe = 1'(fwe); v.fl = 4'(fl); v.re = 1'(re); v.rs = 4'(rs);
        v.r0 = 4'(r0); v.r1 = 4'(r1); v.d0 = d0; v.d1 = d1;
        v.b0 = 1'(b0); v.b1 = 1'(b1); v.of = 4'(of); v.mask = 15'(mask); v.err = 1'(err);
        return v;
    endfunction

    // Behavioural model state and expected registered outputs.
    logic [DW-1:0]    m_regs [NR];
    logic [NR-1:0]    m_busy;
    logic [FW-1:0]    m_flags;
    logic [RP*DW-1:0] e_rd;
    logic [RP-1:0]    e_rb;
    logic [FW-1:0]    e_of;
    logic             e_err;

    task automatic model_clear();
        for (int i = 0; i < NR; i++) m_regs[i] = '0;
        m_busy = '0; m_flags = '0; e_rd = '0; e_rb = '0; e_of = '0; e_err = 1'b0;
    endtask

    task automatic model_step();
        bit wr_ok, rsv_ok;
        int s;
        if (bus.not_enable) begin
            e_err = 1'b0;
            return;
        end
        wr_ok  = bus.wr_en && (int'(bus.wr_sel) < NR);
        rsv_ok = bus.rsv_en && (int'(bus.rsv_sel) < NR);
        e_err  = (bus.wr_en && !wr_ok) || (bus.rsv_en && !rsv_ok);
        for (int k = 0; k < RP; k++) begin
            s = int'(bus.rd_sel[k*AW +: AW]);
            if (s >= NR) begin
                e_err = 1'b1;
                e_rd[k*DW +: DW] = '0;
                e_rb[k] = 1'b0;
            end else if (BYP && wr_ok && s == int'(bus.wr_sel)) begin
                e_rd[k*DW +: DW] = bus.wr_data;
                e_rb[k] = rsv_ok && (int'(bus.rsv_sel) == s);
            end else begin
                e_rd[k*DW +: DW] = m_regs[s];
                e_rb[k] = m_busy[s];
            end
        end
        e_of = (BYP && bus.flags_wr_en) ? bus.in_flags : m_flags;
        if (wr_ok) begin
            m_regs[bus.wr_sel] = bus.wr_data;
            m_busy[bus.wr_sel] = 1'b0;
        end
        if (rsv_ok) m_busy[bus.rsv_sel] = 1'b1;
        if (bus.flags_wr_en) m_flags = bus.in_flags;
    endtask

    task automatic idle();
        bus.not_enable = 1'b0; bus.rd_sel = '0; bus.wr_en = 1'b0; bus.wr_sel = '0;
        bus.wr_data = '0; bus.flags_wr_en = 1'b0; bus.in_flags = '0;
        bus.rsv_en = 1'b0; bus.rsv_sel = '0;
    endtask

    task automatic pidle();
        pbus.not_enable = 1'b0; pbus.rd_sel = '0; pbus.wr_en = 1'b0; pbus.wr_sel = '0;
        pbus.wr_data = '0; pbus.flags_wr_en = 1'b0; pbus.in_flags = '0;
        pbus.rsv_en = 1'b0; pbus.rsv_sel = '0;
    endtask

    task automatic check_all(input string tag, input logic [63:0] rd, input logic [63:0] rb,
                             input logic [63:0] of, input logic [63:0] mask, input logic [63:0] err);
        check({tag, ".rd_data"},   64'(bus.rd_data),   rd);
        check({tag, ".rd_busy"},   64'(bus.rd_busy),   rb);
        check({tag, ".out_flags"}, 64'(bus.out_flags), of);
        check({tag, ".busy_mask"}, 64'(bus.busy_mask), mask);
        check({tag, ".err_addr"},  64'(bus.err_addr),  err);
    endtask

    task automatic cycle_check(input string tag);
        model_step();
        @(posedge clk);
        @(negedge clk);
        check_all(tag, 64'(e_rd), 64'(e_rb), 64'(e_of), 64'(m_busy), 64'(e_err));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    vec_t tbl [16];

    initial begin
        tbl[0]  = mk(0,1, 3,'hDEADBEEF,0,0,  0,0,  0,0, 0,0,                   0,0, 0,   0,0);
        tbl[1]  = mk(0,0, 0,0,         0,0,  0,0,  3,3, 'hDEADBEEF,'hDEADBEEF, 0,0, 0,   0,0);
        tbl[2]  = mk(0,0, 0,0,         0,0,  1,7,  7,3, 0,'hDEADBEEF,          0,0, 0,'h80,0);
        tbl[3]  = mk(0,0, 0,0,         0,0,  0,0,  7,0, 0,0,                   1,0, 0,'h80,0);
        tbl[4]  = mk(0,1, 7,'h55,      0,0,  0,0,  3,1, 'hDEADBEEF,0,          0,0, 0,   0,0);
        tbl[5]  = mk(0,1, 7,'h66,      0,0,  1,7,  0,1, 0,0,                   0,0, 0,'h80,0);
        tbl[6]  = mk(0,0, 0,0,         0,0,  0,0,  7,7, 'h66,'h66,             1,1, 0,'h80,0);
        tbl[7]  = mk(1,1, 5,'h1234,    1,'hA,0,0,  5,5, 'h66,'h66,             1,1, 0,'h80,0);
        tbl[8]  = mk(0,1, 5,'h1234,    0,0,  0,0,  7,3, 'h66,'hDEADBEEF,       1,0, 0,'h80,0);
        tbl[9]  = mk(0,0, 0,0,         1,'hA,0,0,  5,0, 'h1234,0,              0,0, BYP ? 'hA : 0,'h80,0);
        tbl[10] = mk(0,0, 0,0,         0,0,  0,0,  5,5, 'h1234,'h1234,         0,0, 'hA,'h80,0);
        tbl[11] = mk(0,1,15,'hFFFFFFFF,0,0,  0,0,  0,1, 0,0,                   0,0, 'hA,'h80,1);
        tbl[12] = mk(0,0, 0,0,         0,0,  0,0,  0,3, 0,'hDEADBEEF,          0,0, 'hA,'h80,0);
        tbl[13] = mk(0,0, 0,0,         0,0,  0,0, 15,5, 0,'h1234,              0,0, 'hA,'h80,1);
        tbl[14] = mk(0,0, 0,0,         0,0,  1,15, 7,0, 'h66,0,                1,0, 'hA,'h80,1);
        tbl[15] = mk(0,0, 0,0,         0,0,  0,0,  0,0, 0,0,                   0,0, 'hA,'h80,0);

        rst = 1'b1;
        idle();
        pidle();
        repeat (2) @(negedge clk);
        check_all("reset", 0, 0, 0, 0, 0);
        rst = 1'b0;

        for (int i = 0; i < 16; i++) begin
            bus.not_enable  = tbl[i].ne;
            bus.wr_en       = tbl[i].we;
            bus.wr_sel      = tbl[i].ws;
            bus.wr_data     = tbl[i].wd;
            bus.flags_wr_en = tbl[i].fwe;
            bus.in_flags    = tbl[i].fl;
            bus.rsv_en      = tbl[i].re;
            bus.rsv_sel     = tbl[i].rs;
            bus.rd_sel      = {tbl[i].r1, tbl[i].r0};
            @(posedge clk);
            @(negedge clk);
            check_all($sformatf("tbl%0d", i), {tbl[i].d1, tbl[i].d0}, 64'({tbl[i].b1, tbl[i].b0}),
                      64'(tbl[i].of), 64'(tbl[i].mask), 64'(tbl[i].err));
        end

        // Asynchronous reset mid-cycle, held across an edge carrying a write that must be lost.
        #2 rst = 1'b1;
        #1 check_all("async_reset", 0, 0, 0, 0, 0);
        bus.wr_en = 1'b1; bus.wr_sel = 4'd3; bus.wr_data = 32'hCAFEF00D;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        idle();
        model_clear();

        for (int r = 0; r < NR; r++) begin
            bus.rd_sel = {4'(r), 4'(r)};
            cycle_check($sformatf("sweep_r%0d", r));
        end

        for (int n = 0; n < 400; n++) begin
            bus.not_enable  = ($urandom_range(0, 7) == 0);
            bus.wr_en       = 1'($urandom_range(0, 1));
            bus.wr_sel      = 4'($urandom_range(0, 15));
            bus.wr_data     = $urandom;
            bus.flags_wr_en = ($urandom_range(0, 3) == 0);
            bus.in_flags    = 4'($urandom);
            bus.rsv_en      = ($urandom_range(0, 2) == 0);
            bus.rsv_sel     = ($urandom_range(0, 1) == 0) ? bus.wr_sel : 4'($urandom_range(0, 15));
            bus.rd_sel      = 8'($urandom);
            cycle_check($sformatf("rand%0d", n));
        end
        idle();

        for (int i = 0; i < 8; i++) begin
            pbus.wr_en   = 1'b1;
            pbus.wr_sel  = 3'(i);
            pbus.wr_data = 16'(i * 'h1111);
            @(posedge clk);
            @(negedge clk);
        end
        pidle();
        pbus.rd_sel = {3'd1, 3'd7, 3'd2, 3'd1};
        @(posedge clk);
        @(negedge clk);
        check("param.rd_data",   64'(pbus.rd_data),   64'h1111_7777_2222_1111);
        check("param.rd_busy",   64'(pbus.rd_busy),   64'h0);
        check("param.busy_mask", 64'(pbus.busy_mask), 64'h0);
        check("param.err_addr",  64'(pbus.err_addr),  64'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
